core_boot_ctrl: RTL
===================

// Module: core_boot_ctrl
// PURPOSE
//  Synthesizable boot/test controller placed beside CoreTop; replaces the bench-side hex loading and signature polling.
//  Streams words into instruction memory, then data memory, and holds the core in reset for a settle delay.
//  It then releases the core at BOOT_ADDR and monitors mscratch (CSR 0x340) writes for pass/fail signatures.
//  Adds a run-cycle counter, a programmable timeout and restart.
// PARAMETERS
//  INST_WORDS   1024           words loaded into instruction memory (>=1)
//  DATA_WORDS   512            words loaded into data memory (>=1)
//  BOOT_ADDR    32'hFFFF_0000  value driven on boot_addr
//  RELEASE_DLY  10             cycles core stays in reset after last data word (>=1)
//  PASS_SIG     32'hFFFF_1234  mscratch value meaning test passed
//  FAIL_SIG     32'h1234_FFFF  mscratch value meaning test failed
//  CNT_W        32             width of timeout/cycle counters
// PORTS
//  clk            in   1                    clock, all logic on rising edge
//  rst            in   1                    asynchronous, active-high reset
//  restart        in   1                    1-cycle pulse: reload and rerun, accepted only in DONE
//  ld_valid       in   1                    load word valid
//  ld_data        in   32                   load word
//  ld_ready       out  1                    controller accepts ld_data this cycle
//  imem_we        out  1                    instruction memory write strobe
//  imem_addr      out  $clog2(INST_WORDS)   instruction memory word index
//  dmem_we        out  1                    data memory write strobe
//  dmem_addr      out  $clog2(DATA_WORDS)   data memory word index
//  mem_wdata      out  32                   write data, shared by both memories
//  core_rstn      out  1                    active-low reset to CoreTop
//  boot_addr      out  32                   initial PC to CoreTop
//  csr_we         in   1                    core CSR write strobe
//  csr_addr       in   12                   core CSR write address
//  csr_wdata      in   32                   core CSR write data
//  timeout_cycles in   CNT_W                run-cycle limit; 0 = no timeout
//  done           out  1                    sticky: test ended (pass, fail or timeout)
//  pass / fail    out  1                    sticky result flags, mutually exclusive
//  timeout        out  1                    sticky: timeout_cycles reached with no signature
//  cycle_count    out  CNT_W                cycles spent in RUN, saturating at all-ones
// BEHAVIOUR
//  Reset: state=LOAD_I, indices=0, ld_ready=0, imem_we/dmem_we=0, mem_wdata=0, core_rstn=0.
//  Reset also clears done/pass/fail/timeout=0 and cycle_count=0; boot_addr=BOOT_ADDR at all times.
//  States: LOAD_I -> LOAD_D -> HOLD -> RUN -> DONE; DONE -restart-> LOAD_I.
//  ld_ready = 1 only in LOAD_I/LOAD_D (registered, goes 1 first cycle after rst falls).
//   Accept = ld_valid & ld_ready.
//  Write latency 1: accept at cycle N -> *_we=1, addr=current index, mem_wdata=ld_data at cycle N+1; we is a 1-cycle pulse.
//  LOAD_I: index increments per accept; the INST_WORDS-th accept moves to LOAD_D with the index reset to 0.
//   ld_ready stays 1 across the boundary, so back-to-back words are not stalled.
//  LOAD_D: same, DATA_WORDS accepts -> HOLD; ld_ready=0 from the cycle after the last accept.
//  HOLD: core_rstn=0 for exactly RELEASE_DLY cycles, then RUN; core_rstn=1 in the first RUN cycle.
//  RUN: cycle_count += 1 per cycle (saturating).
//   A CSR write is a match when csr_we=1 and csr_addr=12'h340.
//   Match with csr_wdata==PASS_SIG -> DONE, pass=1. Match with FAIL_SIG -> DONE, fail=1.
//   Any other write, or any other CSR, is ignored.
//  Timeout: in RUN with timeout_cycles!=0 and cycle_count==timeout_cycles-1 -> DONE, timeout=1.
//   A signature match in the same cycle wins: pass/fail=1, timeout=0.
//  done=1 in the same cycle the flag is set; flags change only on rst/restart.
//  DONE: core_rstn=0 (core frozen); cycle_count holds; ld_valid ignored.
//  restart in DONE: next cycle LOAD_I, all flags/cycle_count/indices cleared, core_rstn=0.
//   restart in any other state is ignored.
//  rst mid-load or mid-run: immediate return to reset values; partially written memory is not cleared.
// TESTING
//  1. INST_WORDS=4, DATA_WORDS=2, continuous ld_valid with words 1..6:
//     imem writes idx0..3 = 1..4, dmem writes idx0..1 = 5..6, no bubbles.
//     core_rstn rises RELEASE_DLY cycles after the last dmem_we.
//  2. During RUN, csr write 0x340 <= 32'hFFFF_1234 -> done=1, pass=1, core_rstn=0 the next cycle.
//  3. During RUN, csr write 0x340 <= 32'h1234_FFFF -> fail=1.
//     A prior write of 0x340 <= 0xDEAD and of 0x341 <= PASS_SIG changes nothing.
//  4. timeout_cycles=50, no signature -> timeout=1, done=1 at cycle_count==49 (counter holds).
//     Rerun with PASS at run cycle 49 -> pass=1, timeout=0.
//  5. timeout_cycles=0, run 10000 cycles -> no timeout. Drive ld_valid with gaps -> indices advance only on accepts.
//  6. restart in DONE -> reload 6 words, flags clear. restart during RUN is ignored.
//     rst asserted mid-LOAD_D -> ld_ready=0, state LOAD_I, index 0.

Source files
------------

// File: rtl/core_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : core_boot_ctrl
//  Purpose  : Boot/test controller for CoreTop. It streams a program image into
//             instruction memory and then data memory, and holds the core in
//             reset for a settle delay. It then releases the core and watches
//             mscratch writes for a pass/fail signature, with a run-cycle
//             counter, an optional timeout and restart.
//  Revision : 1.0 - initial release
// ============================================================================
module core_boot_ctrl #(
  parameter int          INST_WORDS  = 1024,
  parameter int          DATA_WORDS  = 512,
  parameter logic [31:0] BOOT_ADDR   = 32'hFFFF_0000,
  parameter int          RELEASE_DLY = 10,
  parameter logic [31:0] PASS_SIG    = 32'hFFFF_1234,
  parameter logic [31:0] FAIL_SIG    = 32'h1234_FFFF,
  parameter int          CNT_W       = 32,
  localparam int         IA_W        = (INST_WORDS > 1) ? $clog2(INST_WORDS) : 1,
  localparam int         DA_W        = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic             imem_we,
  output logic [IA_W-1:0]  imem_addr,
  output logic             dmem_we,
  output logic [DA_W-1:0]  dmem_addr,
  output logic [31:0]      mem_wdata,
  output logic             core_rstn,
  output logic [31:0]      boot_addr,
  input  logic             csr_we,
  input  logic [11:0]      csr_addr,
  input  logic [31:0]      csr_wdata,
  input  logic [CNT_W-1:0] timeout_cycles,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  // One shared load index serves both memories, so it is sized for the larger.
  localparam int               IDX_W    = (IA_W > DA_W) ? IA_W : DA_W;
  localparam int               HLD_W    = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
  localparam logic [IDX_W-1:0] I_LAST   = IDX_W'(INST_WORDS - 1);
  localparam logic [IDX_W-1:0] D_LAST   = IDX_W'(DATA_WORDS - 1);
  localparam logic [HLD_W-1:0] H_LAST   = HLD_W'(RELEASE_DLY - 1);
  localparam logic [11:0]      MSCRATCH = 12'h340;

  localparam logic [2:0] S_LOAD_I = 3'd0;
  localparam logic [2:0] S_LOAD_D = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HLD_W-1:0] hold_q, hold_d;
  logic             ld_ready_q, ld_ready_d;
  logic             imem_we_q, imem_we_d;
  logic             dmem_we_q, dmem_we_d;
  logic [IA_W-1:0]  imem_addr_q, imem_addr_d;
  logic [DA_W-1:0]  dmem_addr_q, dmem_addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             core_rstn_q, core_rstn_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic csr_hit;
  logic tmo_hit;

  assign accept  = ld_valid & ld_ready_q;
  assign csr_hit = csr_we & (csr_addr == MSCRATCH);
  assign tmo_hit = (timeout_cycles != '0) && (cnt_q == timeout_cycles - CNT_W'(1));

  // Next-state logic: load sequencing, reset hold, run monitoring and restart.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    ld_ready_d  = 1'b0;
    imem_we_d   = 1'b0;
    dmem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    dmem_addr_d = dmem_addr_q;
    wdata_d     = wdata_q;
    core_rstn_d = core_rstn_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_LOAD_I: begin
        // Ready stays high into LOAD_D so a back-to-back stream never stalls.
        ld_ready_d = 1'b1;
        if (accept) begin
          imem_we_d   = 1'b1;
          imem_addr_d = idx_q[IA_W-1:0];
          wdata_d     = ld_data;
          if (idx_q == I_LAST) begin
            idx_d   = '0;
            state_d = S_LOAD_D;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_LOAD_D: begin
        ld_ready_d = 1'b1;
        if (accept) begin
          dmem_we_d   = 1'b1;
          dmem_addr_d = idx_q[DA_W-1:0];
          wdata_d     = ld_data;
          if (idx_q == D_LAST) begin
            idx_d      = '0;
            hold_d     = '0;
            ld_ready_d = 1'b0;
            state_d    = S_HOLD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (hold_q == H_LAST) begin
          core_rstn_d = 1'b1;
          state_d     = S_RUN;
        end else begin
          hold_d = hold_q + HLD_W'(1);
        end
      end
      S_RUN: begin
        // A signature wins over a timeout landing in the same cycle; the
        // counter is frozen on the terminating cycle so it reads the end cycle.
        if (csr_hit && (csr_wdata == PASS_SIG)) begin
          pass_d      = 1'b1;
          done_d      = 1'b1;
          core_rstn_d = 1'b0;
          state_d     = S_DONE;
        end else if (csr_hit && (csr_wdata == FAIL_SIG)) begin
          fail_d      = 1'b1;
          done_d      = 1'b1;
          core_rstn_d = 1'b0;
          state_d     = S_DONE;
        end else if (tmo_hit) begin
          timeout_d   = 1'b1;
          done_d      = 1'b1;
          core_rstn_d = 1'b0;
          state_d     = S_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (restart) begin
          idx_d      = '0;
          hold_d     = '0;
          ld_ready_d = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          timeout_d  = 1'b0;
          cnt_d      = '0;
          state_d    = S_LOAD_I;
        end
      end
      default: begin
        state_d = S_LOAD_I;
      end
    endcase
  end

  // State and output registers, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD_I;
      idx_q       <= '0;
      hold_q      <= '0;
      ld_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      dmem_addr_q <= '0;
      wdata_q     <= '0;
      core_rstn_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      ld_ready_q  <= ld_ready_d;
      imem_we_q   <= imem_we_d;
      dmem_we_q   <= dmem_we_d;
      imem_addr_q <= imem_addr_d;
      dmem_addr_q <= dmem_addr_d;
      wdata_q     <= wdata_d;
      core_rstn_q <= core_rstn_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ld_ready    = ld_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign mem_wdata   = wdata_q;
  assign core_rstn   = core_rstn_q;
  assign boot_addr   = BOOT_ADDR;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule
`default_nettype wire
